// File: rtl/cdp_pkg.sv
// Shared CDP transmit definitions: beat tags, widths, arbiter FSM encoding.
package cdp_pkg;

  localparam int META_W = 139;
  localparam int RULE_W = 30;

  localparam logic [2:0] TAG_HEAD = 3'b101;
  localparam logic [2:0] TAG_BODY = 3'b100;
  localparam logic [2:0] TAG_TAIL = 3'b110;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RULE    = 2'd1;
  localparam logic [1:0] ST_WAIT_TX = 2'd2;
  localparam logic [1:0] ST_FWD     = 2'd3;

  // Tail beat injected when a granted engine stalls out mid-packet.
  localparam logic [META_W-1:0] SYNTH_TAIL = {TAG_TAIL, 4'hf, 4'b0, 128'b0};

  function automatic logic tag_is_legal(input logic [2:0] tag);
    return (tag == TAG_HEAD) || (tag == TAG_BODY) || (tag == TAG_TAIL);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     win_oh,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_vld
);

  logic [IDX_W-1:0] k;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    k       = '0;
    for (int i = 0; i < N; i++) begin
      k = IDX_W'((int'(ptr) + i) % N);
      if (!win_vld && req[k]) begin
        win_vld    = 1'b1;
        win_idx    = k;
        win_oh[k]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdp_tx_arbiter.sv
// Packet-level round-robin arbiter for the CDP rule FIFO + metadata stream.
// Optional stall watchdog enabled by defining ARB_TIMEOUT_EN.
module cdp_tx_arbiter
  import cdp_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int RULE_THRESH = 28,
  parameter int TIMEOUT     = 1023
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*RULE_W-1:0] req_rule,
  output logic [NUM_REQ-1:0]        grant,
  input  logic [NUM_REQ-1:0]        req_pkt_valid,
  input  logic [NUM_REQ*META_W-1:0] req_pkt,
  output logic                      um2cdp_rule_wrreq,
  output logic [RULE_W-1:0]         um2cdp_rule,
  input  logic [4:0]                cdp2um_rule_usedw,
  input  logic                      cdp2um_tx_enable,
  output logic                      metadata_out_valid,
  output logic [META_W-1:0]         metadata_out,
`ifdef ARB_TIMEOUT_EN
  output logic                      timeout_err,
`endif
  output logic                      busy
);

  localparam int         SEL_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [4:0] THRESH = 5'(RULE_THRESH);

  logic [1:0]         state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NUM_REQ-1:0] sel_oh_q, sel_oh_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               wrreq_q, wrreq_d;
  logic [RULE_W-1:0]  rule_q, rule_d;
  logic               mvld_q, mvld_d;
  logic [META_W-1:0]  meta_q, meta_d;

  logic [NUM_REQ-1:0] pick_oh;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_vld;
  logic               beat_vld;
  logic [META_W-1:0]  beat;
  logic [SEL_W-1:0]   ptr_next;

  rr_pick #(.N(NUM_REQ), .IDX_W(SEL_W)) u_pick (
    .req     (req_valid),
    .ptr     (ptr_q),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .win_vld (pick_vld)
  );

  assign beat_vld = req_pkt_valid[sel_q];
  assign beat     = req_pkt[int'(sel_q)*META_W +: META_W];
  assign ptr_next = (sel_q == SEL_W'(NUM_REQ-1)) ? '0 : sel_q + 1'b1;

`ifdef ARB_TIMEOUT_EN
  logic [9:0] to_cnt_q, to_cnt_d;
  logic       to_err_q, to_err_d;
`else
  logic [9:0] unused_timeout;
  assign unused_timeout = 10'(TIMEOUT);
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    sel_oh_d = sel_oh_q;
    grant_d  = grant_q;
    wrreq_d  = 1'b0;
    rule_d   = rule_q;
    mvld_d   = 1'b0;
    meta_d   = meta_q;
`ifdef ARB_TIMEOUT_EN
    to_cnt_d = '0;
    to_err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_vld && (cdp2um_rule_usedw <= THRESH)) begin
          sel_d    = pick_idx;
          sel_oh_d = pick_oh;
          state_d  = ST_RULE;
        end
      end
      ST_RULE: begin
        wrreq_d = 1'b1;
        rule_d  = req_rule[int'(sel_q)*RULE_W +: RULE_W];
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (cdp2um_tx_enable) begin
          grant_d = sel_oh_q;
          state_d = ST_FWD;
        end
      end
      default: begin
        mvld_d = beat_vld;
        meta_d = beat;
        if (beat_vld && (beat[META_W-1 -: 3] == TAG_TAIL)) begin
          grant_d = '0;
          ptr_d   = ptr_next;
          state_d = ST_IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        // Counter holds the number of consecutive beat-less cycles so far.
        else if (!beat_vld && (to_cnt_q == 10'(TIMEOUT - 1))) begin
          mvld_d   = 1'b1;
          meta_d   = SYNTH_TAIL;
          grant_d  = '0;
          ptr_d    = ptr_next;
          state_d  = ST_IDLE;
          to_err_d = 1'b1;
        end else if (!beat_vld) begin
          to_cnt_d = to_cnt_q + 10'd1;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      sel_q    <= '0;
      sel_oh_q <= '0;
      grant_q  <= '0;
      wrreq_q  <= 1'b0;
      rule_q   <= '0;
      mvld_q   <= 1'b0;
      meta_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      sel_oh_q <= sel_oh_d;
      grant_q  <= grant_d;
      wrreq_q  <= wrreq_d;
      rule_q   <= rule_d;
      mvld_q   <= mvld_d;
      meta_q   <= meta_d;
`ifdef ARB_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
`endif
    end
  end

  assign grant              = grant_q;
  assign um2cdp_rule_wrreq  = wrreq_q;
  assign um2cdp_rule        = rule_q;
  assign metadata_out_valid = mvld_q;
  assign metadata_out       = meta_q;
  assign busy               = (state_q != ST_IDLE);
`ifdef ARB_TIMEOUT_EN
  assign timeout_err        = to_err_q;
`endif

endmodule

// File: tb/tb_cdp_tx_arbiter.sv
// Directed self-checking bench for cdp_tx_arbiter (NUM_REQ=2).
module tb_cdp_tx_arbiter;
  import cdp_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [1:0]   req_valid = '0;
  logic [59:0]  req_rule = '0;
  logic [1:0]   grant;
  logic [1:0]   req_pkt_valid = '0;
  logic [277:0] req_pkt = '0;
  logic         wrreq;
  logic [29:0]  rule;
  logic [4:0]   usedw = '0;
  logic         tx_enable = 1'b0;
  logic         mvld;
  logic [138:0] meta;
  logic         busy;
`ifdef ARB_TIMEOUT_EN
  logic         timeout_err;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cdp_tx_arbiter #(
    .NUM_REQ(2), .RULE_THRESH(28)
`ifdef ARB_TIMEOUT_EN
    , .TIMEOUT(8)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rule(req_rule), .grant(grant),
    .req_pkt_valid(req_pkt_valid), .req_pkt(req_pkt),
    .um2cdp_rule_wrreq(wrreq), .um2cdp_rule(rule),
    .cdp2um_rule_usedw(usedw), .cdp2um_tx_enable(tx_enable),
    .metadata_out_valid(mvld), .metadata_out(meta),
`ifdef ARB_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .busy(busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [138:0] obs, input logic [138:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int r);
    logic [1:0] v;
    v = 2'b01 << r;
    return v;
  endfunction

  // From IDLE with req_valid already set: pick, rule write, tx handshake, grant.
  task automatic open_pkt(input int w, input logic [29:0] exp_rule, input int txdelay,
                          input logic [4:0] usedw_after);
    tick;
    check("busy_rule", busy, 1);
    check("wrreq_early", wrreq, 0);
    tick;
    check("wrreq", wrreq, 1);
    check("rule", rule, exp_rule);
    usedw = usedw_after;
    for (int i = 0; i < txdelay; i++) begin
      tick;
      check("wrreq_pulse", wrreq, 0);
      check("grant_wait", grant, 0);
    end
    tx_enable = 1'b1;
    tick;
    check("grant", grant, oh(w));
    tx_enable = 1'b0;
  endtask

  task automatic run_beats(input int r, input int n, input logic [31:0] seed,
                           input bit noise, input bit with_tail);
    logic [138:0] beat;
    logic [2:0]   tag;
    for (int b = 0; b < n; b++) begin
      if (b == 0) tag = TAG_HEAD;
      else if (with_tail && b == n - 1) tag = TAG_TAIL;
      else tag = TAG_BODY;
      beat = {tag, 104'h0, seed + 32'(b)};
      req_pkt_valid = '0;
      req_pkt_valid[r] = 1'b1;
      req_pkt[r*139 +: 139] = beat;
      if (noise) begin
        req_pkt_valid[1-r] = 1'b1;
        req_pkt[(1-r)*139 +: 139] = {TAG_TAIL, 104'h0, 32'hdead0000 + 32'(b)};
      end
      tick;
      check("beat_vld", mvld, 1);
      check("beat_data", meta, beat);
      if (tag == TAG_TAIL) begin
        check("grant_tail", grant, 0);
        check("busy_tail", busy, 0);
      end else begin
        check("grant_hold", grant, oh(r));
        check("busy_fwd", busy, 1);
      end
    end
    req_pkt_valid = '0;
  endtask

  initial begin
    // reset state
    repeat (2) tick;
    check("rst_grant", grant, 0);
    check("rst_wrreq", wrreq, 0);
    check("rst_rule", rule, 0);
    check("rst_mvld", mvld, 0);
    check("rst_meta", meta, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    tick;

    // single packet, tx_enable 3 cycles late
    req_valid = 2'b01;
    req_rule[29:0] = 30'h5;
    open_pkt(0, 30'h5, 3, 5'd0);
    req_valid = '0;
    run_beats(0, 4, 32'h100, 1'b0, 1'b1);
    tick;
    check("idle_mvld", mvld, 0);
    check("idle_busy", busy, 0);

    // same requester again: pointer is 1, search wraps to 0
    req_valid = 2'b01;
    req_rule[29:0] = 30'h1234567;
    open_pkt(0, 30'h1234567, 0, 5'd0);
    req_valid = '0;
    run_beats(0, 2, 32'h200, 1'b0, 1'b1);

    // pointer returns to 0 on reset, then strict alternation
    reset = 1'b0;
    tick;
    reset = 1'b1;
    req_rule = {30'h2bbbbbbb, 30'h0aaaaaaa};
    req_valid = 2'b11;
    open_pkt(0, 30'h0aaaaaaa, 0, 5'd0);
    run_beats(0, 3, 32'h300, 1'b0, 1'b1);
    open_pkt(1, 30'h2bbbbbbb, 1, 5'd0);
    run_beats(1, 2, 32'h400, 1'b0, 1'b1);
    open_pkt(0, 30'h0aaaaaaa, 0, 5'd0);
    run_beats(0, 2, 32'h500, 1'b0, 1'b1);
    open_pkt(1, 30'h2bbbbbbb, 0, 5'd0);
    run_beats(1, 3, 32'h600, 1'b0, 1'b1);
    req_valid = '0;
    tick;

    // threshold gating, late usedw rise, and isolation from requester 1
    usedw = 5'd29;
    req_valid = 2'b01;
    req_rule[29:0] = 30'h3c3c3c3;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("thr_busy", busy, 0);
      check("thr_wrreq", wrreq, 0);
    end
    usedw = 5'd28;
    open_pkt(0, 30'h3c3c3c3, 0, 5'd31);
    req_valid = '0;
    run_beats(0, 3, 32'h700, 1'b1, 1'b1);
    usedw = 5'd0;
    tick;
    check("iso_mvld", mvld, 0);

    // reset after the 2nd beat
    req_valid = 2'b01;
    open_pkt(0, 30'h3c3c3c3, 0, 5'd0);
    req_valid = '0;
    run_beats(0, 2, 32'h800, 1'b0, 1'b0);
    tick;
    check("gap_mvld", mvld, 0);
    check("gap_grant", grant, 2'b01);
    reset = 1'b0;
    #1;
    check("mid_grant", grant, 0);
    check("mid_mvld", mvld, 0);
    check("mid_meta", meta, 0);
    check("mid_busy", busy, 0);
    check("mid_rule", rule, 0);
    tick;
    reset = 1'b1;
    req_valid = 2'b10;
    req_rule[59:30] = 30'h1f00f;
    open_pkt(1, 30'h1f00f, 0, 5'd0);
    req_valid = '0;
    run_beats(1, 2, 32'h900, 1'b0, 1'b1);
    tick;

`ifdef ARB_TIMEOUT_EN
    // engine stalls after its head beat
    req_valid = 2'b01;
    open_pkt(0, 30'h3c3c3c3, 0, 5'd0);
    req_valid = '0;
    run_beats(0, 1, 32'ha00, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick;
      check("to_quiet", mvld, 0);
      check("to_err_low", timeout_err, 0);
    end
    tick;
    check("to_vld", mvld, 1);
    check("to_meta", meta, {TAG_TAIL, 4'hf, 4'b0, 128'b0});
    check("to_err", timeout_err, 1);
    check("to_grant", grant, 0);
    tick;
    check("to_err_pulse", timeout_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
